// File: rtl/inventory_scan_seq.sv
// ---------------------------------------------------------------------------
// inventory_scan_seq
//   Scan sequencer for NUM_CH load-cell channels. A rising edge on ctrl_start
//   (while ctrl_enable=1) walks every channel through a req/valid ADC port,
//   averages 2**AVG_LOG2 samples per channel and emits one result strobe per
//   channel. Sticky done/timeout/overrun flags feed core_status and irq_o.
//
//   Ports
//     wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//     ctrl_enable             0 forces the sequencer back to IDLE
//     ctrl_start              rising edge starts a scan
//     irq_en[2:0]             mask for {overrun, timeout, done}
//     adc_req_o, adc_ch_o     sample request and its channel
//     adc_valid_i, adc_data_i sample handshake, 24-bit unsigned data
//     res_valid_o             1-cycle result strobe
//     res_ch_o, res_data_o    channel / averaged value of last result (held)
//     core_status[7:0]        {ch[3:0], overrun, timeout, done, busy}
//     irq_o                   |(sticky flags & irq_en)
//
//   Build option
//     SCAN_CONT_EN  when defined, DONE restarts at channel 0 if ctrl_enable
//                   and ctrl_start are still high (continuous scanning).
//
//   state | meaning
//   IDLE  | waiting for a start edge
//   REQ   | adc_req_o high, collecting samples for channel ch
//   RES   | result strobe out, advance channel or finish
//   DONE  | scan complete, done flag raised
// ---------------------------------------------------------------------------
module inventory_scan_seq #(
    parameter int NUM_CH   = 4,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        ctrl_enable,
    input  logic        ctrl_start,
    input  logic [2:0]  irq_en,
    output logic        adc_req_o,
    output logic [3:0]  adc_ch_o,
    input  logic        adc_valid_i,
    input  logic [23:0] adc_data_i,
    output logic        res_valid_o,
    output logic [3:0]  res_ch_o,
    output logic [23:0] res_data_o,
    output logic [7:0]  core_status,
    output logic        irq_o
);

    localparam int ACC_W = 24 + AVG_LOG2;
    localparam int SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
    localparam logic [3:0]       CH_LAST  = 4'(NUM_CH - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RES, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               start_q;
    logic [3:0]         ch_q, ch_d;
    logic [SMP_W-1:0]   smp_q, smp_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               done_q, done_d;
    logic               tmo_flag_q, tmo_flag_d;
    logic               ovr_q, ovr_d;
    logic               res_valid_q, res_valid_d;
    logic [3:0]         res_ch_q, res_ch_d;
    logic [23:0]        res_data_q, res_data_d;

    logic               start_pulse;
    logic               accept;
    logic [ACC_W-1:0]   acc_sum;

    assign start_pulse = ctrl_start & ~start_q & ctrl_enable;
    assign accept      = (state_q == S_REQ) & adc_valid_i & ctrl_enable;
    assign acc_sum     = acc_q + ACC_W'(adc_data_i);

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        smp_d       = smp_q;
        acc_d       = acc_q;
        tmo_d       = tmo_q;
        done_d      = done_q;
        tmo_flag_d  = tmo_flag_q;
        ovr_d       = ovr_q;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;

        if (start_pulse && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_pulse) begin
                    done_d     = 1'b0;
                    tmo_flag_d = 1'b0;
                    ovr_d      = 1'b0;
                    ch_d       = '0;
                    smp_d      = '0;
                    acc_d      = '0;
                    tmo_d      = TMO_LOAD;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                // An accept in the terminal-count cycle wins over the timeout.
                if (accept) begin
                    tmo_d = TMO_LOAD;
                    if (smp_q == SMP_LAST) begin
                        // Result is registered here so data/ch are stable with the strobe.
                        res_valid_d = 1'b1;
                        res_ch_d    = ch_q;
                        res_data_d  = acc_sum[AVG_LOG2 +: 24];
                        acc_d       = '0;
                        smp_d       = '0;
                        state_d     = S_RES;
                    end else begin
                        acc_d = acc_sum;
                        smp_d = smp_q + SMP_W'(1);
                    end
                end else if (tmo_q == '0) begin
                    tmo_flag_d = 1'b1;
                    acc_d      = '0;
                    smp_d      = '0;
                    state_d    = S_IDLE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            S_RES: begin
                if (ch_q == CH_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 4'd1;
                    tmo_d   = TMO_LOAD;
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
`ifdef SCAN_CONT_EN
                if (ctrl_enable && ctrl_start) begin
                    ch_d    = '0;
                    smp_d   = '0;
                    acc_d   = '0;
                    tmo_d   = TMO_LOAD;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Disable aborts everything in flight but keeps the sticky flags as they were.
        if (!ctrl_enable && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            ch_d        = ch_q;
            acc_d       = '0;
            smp_d       = '0;
            done_d      = done_q;
            tmo_flag_d  = tmo_flag_q;
            res_valid_d = 1'b0;
            res_ch_d    = res_ch_q;
            res_data_d  = res_data_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            ch_q        <= '0;
            smp_q       <= '0;
            acc_q       <= '0;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            tmo_flag_q  <= 1'b0;
            ovr_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= ctrl_start;
            ch_q        <= ch_d;
            smp_q       <= smp_d;
            acc_q       <= acc_d;
            tmo_q       <= tmo_d;
            done_q      <= done_d;
            tmo_flag_q  <= tmo_flag_d;
            ovr_q       <= ovr_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
        end
    end

    assign adc_req_o   = (state_q == S_REQ);
    assign adc_ch_o    = ch_q;
    assign res_valid_o = res_valid_q;
    assign res_ch_o    = res_ch_q;
    assign res_data_o  = res_data_q;
    assign core_status = {ch_q, ovr_q, tmo_flag_q, done_q, (state_q != S_IDLE)};
    assign irq_o       = |({ovr_q, tmo_flag_q, done_q} & irq_en);

endmodule

// File: tb/tb_inventory_scan_seq.sv
// ---------------------------------------------------------------------------
// tb_inventory_scan_seq
//   Directed bench for inventory_scan_seq (NUM_CH=4, AVG_LOG2=2, TIMEOUT=1023).
//   A table of full-scan vectors is applied in a loop; hand-written sequences
//   cover timeout, overrun, enable abort, held start and reset mid-scan.
//   Honours SCAN_CONT_EN for the held-start sequence.
// ---------------------------------------------------------------------------
module tb_inventory_scan_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_enable;
    logic        ctrl_start;
    logic [2:0]  irq_en;
    logic        adc_req;
    logic [3:0]  adc_ch;
    logic        adc_valid;
    logic [23:0] adc_data;
    logic        res_valid;
    logic [3:0]  res_ch;
    logic [23:0] res_data;
    logic [7:0]  core_status;
    logic        irq;

    inventory_scan_seq #(.NUM_CH(4), .AVG_LOG2(2), .TIMEOUT(1023)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .ctrl_enable (ctrl_enable),
        .ctrl_start  (ctrl_start),
        .irq_en      (irq_en),
        .adc_req_o   (adc_req),
        .adc_ch_o    (adc_ch),
        .adc_valid_i (adc_valid),
        .adc_data_i  (adc_data),
        .res_valid_o (res_valid),
        .res_ch_o    (res_ch),
        .res_data_o  (res_data),
        .core_status (core_status),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // ADC behaviour: 0 never valid, 1 valid tied high, 2 valid one cycle after each request
    int adc_mode = 0;
    bit data_ff  = 1'b0;

    // result log
    int          res_cnt = 0;
    logic [3:0]  rch  [64];
    logic [23:0] rdat [64];
    int          rcyc [64];
    int          done_cyc = 0;

    typedef struct {
        logic [2:0]  irq_en;
        int          mode;
        bit          data_ff;
        logic [23:0] exp_base;
        logic [23:0] exp_step;
        logic [7:0]  exp_status;
        logic        exp_irq;
        int          exp_period;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick(1);
            if (!core_status[0]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bit   acc_now;
        int   wait_cnt;
        int   idx;
        logic [3:0] last_ch;
        adc_valid = 1'b0;
        adc_data  = '0;
        wait_cnt  = 0;
        idx       = 0;
        last_ch   = '0;
        forever begin
            @(negedge clk);
            acc_now = adc_req && adc_valid;
            @(posedge clk);
            #1;
            if (acc_now) begin
                idx++;
                wait_cnt = 0;
            end
            if (adc_ch != last_ch) idx = 0;
            last_ch = adc_ch;
            case (adc_mode)
                1: adc_valid = 1'b1;
                2: begin
                    if (adc_req) begin
                        adc_valid = (wait_cnt >= 1);
                        wait_cnt++;
                    end else begin
                        adc_valid = 1'b0;
                        wait_cnt  = 0;
                    end
                end
                default: adc_valid = 1'b0;
            endcase
            adc_data = data_ff ? 24'hFFFFFF : ({20'd0, adc_ch} << 8) + 24'(idx);
        end
    end

    initial begin
        bit done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (res_valid) begin
                rch[res_cnt & 63]  = res_ch;
                rdat[res_cnt & 63] = res_data;
                rcyc[res_cnt & 63] = cyc;
                res_cnt++;
            end
            if (core_status[1] && !done_prev) done_cyc = cyc;
            done_prev = core_status[1];
        end
    end

    task automatic run_scan(input vec_t v, input int vi);
        int base;
        bit ok;
        int last;
        adc_mode    = v.mode;
        data_ff     = v.data_ff;
        irq_en      = v.irq_en;
        ctrl_enable = 1'b1;
        base        = res_cnt;
        ctrl_start  = 1'b1;
        tick(1);
        ctrl_start  = 1'b0;
        wait_idle(2000, ok);
        chk($sformatf("v%0d_idle", vi), 32'(ok), 32'd1);
        chk($sformatf("v%0d_nres", vi), 32'(res_cnt - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("v%0d_ch%0d", vi, i), 32'(rch[(base + i) & 63]), 32'(i));
            chk($sformatf("v%0d_data%0d", vi, i), 32'(rdat[(base + i) & 63]),
                32'(v.exp_base + v.exp_step * 24'(i)));
            if (i > 0)
                chk($sformatf("v%0d_period%0d", vi, i),
                    32'(rcyc[(base + i) & 63] - rcyc[(base + i - 1) & 63]), 32'(v.exp_period));
        end
        last = rcyc[(base + 3) & 63];
        chk($sformatf("v%0d_done_lat", vi), 32'(done_cyc - last), 32'd1);
        chk($sformatf("v%0d_status", vi), 32'(core_status), 32'(v.exp_status));
        chk($sformatf("v%0d_irq", vi), 32'(irq), 32'(v.exp_irq));
    endtask

    initial begin
        int  base;
        int  n;
        bit  ok;

        vecs[0] = '{3'b001, 2, 1'b0, 24'h000001, 24'h000100, 8'h32, 1'b1, 9};
        vecs[1] = '{3'b110, 2, 1'b0, 24'h000001, 24'h000100, 8'h32, 1'b0, 9};
        vecs[2] = '{3'b001, 1, 1'b0, 24'h000001, 24'h000100, 8'h32, 1'b1, 5};
        vecs[3] = '{3'b000, 1, 1'b1, 24'hFFFFFF, 24'h000000, 8'h32, 1'b0, 5};

        rst = 1'b1; ctrl_enable = 1'b0; ctrl_start = 1'b0; irq_en = 3'b111;
        tick(3);
        chk("rst_status", 32'(core_status), 32'h0);
        chk("rst_req", 32'(adc_req), 32'h0);
        chk("rst_resv", 32'(res_valid), 32'h0);
        chk("rst_resd", 32'(res_data), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 4; i++) run_scan(vecs[i], i);

        // ADC never answers: request must stay up for exactly TIMEOUT cycles
        adc_mode = 0; irq_en = 3'b010; base = res_cnt;
        ctrl_start = 1'b1;
        tick(1);
        ctrl_start = 1'b0;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!adc_req) break;
            n++;
            tick(1);
        end
        chk("tmo_req_cycles", 32'(n), 32'd1023);
        chk("tmo_status", 32'(core_status), 32'h04);
        chk("tmo_irq", 32'(irq), 32'd1);
        chk("tmo_nres", 32'(res_cnt - base), 32'd0);
        irq_en = 3'b001;
        #1;
        chk("tmo_irq_masked", 32'(irq), 32'd0);

        // second start edge while busy
        adc_mode = 2; data_ff = 1'b0; irq_en = 3'b100; base = res_cnt;
        ctrl_start = 1'b1;
        tick(1);
        ctrl_start = 1'b0;
        tick(6);
        chk("ovr_pre", 32'(core_status[3]), 32'd0);
        ctrl_start = 1'b1;
        tick(1);
        ctrl_start = 1'b0;
        chk("ovr_flag", 32'(core_status[3]), 32'd1);
        chk("ovr_irq", 32'(irq), 32'd1);
        wait_idle(2000, ok);
        chk("ovr_idle", 32'(ok), 32'd1);
        chk("ovr_nres", 32'(res_cnt - base), 32'd4);
        chk("ovr_last_data", 32'(rdat[(base + 3) & 63]), 32'h301);
        chk("ovr_status", 32'(core_status), 32'h3A);

        // enable dropped during channel 2
        irq_en = 3'b001; base = res_cnt;
        ctrl_start = 1'b1;
        tick(1);
        ctrl_start = 1'b0;
        chk("abort_flags_clr", 32'(core_status), 32'h01);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (adc_ch == 4'd2 && adc_req) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        chk("abort_reach_ch2", 32'(ok), 32'd1);
        tick(2);
        ctrl_enable = 1'b0;
        tick(1);
        chk("abort_req", 32'(adc_req), 32'd0);
        chk("abort_status", 32'(core_status), 32'h20);
        tick(10);
        chk("abort_nres", 32'(res_cnt - base), 32'd2);
        chk("abort_status_hold", 32'(core_status), 32'h20);
        chk("abort_irq", 32'(irq), 32'd0);
        run_scan(vecs[0], 4);

        // start held high after the scan
        adc_mode = 1; data_ff = 1'b0; irq_en = 3'b001; base = res_cnt;
        ctrl_start = 1'b1;
        tick(1);
`ifdef SCAN_CONT_EN
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (res_cnt - base >= 8) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        chk("cont_two_scans", 32'(ok), 32'd1);
        chk("cont_restart_ch", 32'(rch[(base + 4) & 63]), 32'd0);
        chk("cont_restart_gap", 32'(rcyc[(base + 4) & 63] - rcyc[(base + 3) & 63]), 32'd6);
        chk("cont_data7", 32'(rdat[(base + 7) & 63]), 32'h301);
        ctrl_enable = 1'b0;
        tick(1);
        ctrl_start = 1'b0;
        tick(2);
        chk("cont_stop_busy", 32'(core_status[0]), 32'd0);
        ctrl_enable = 1'b1;
`else
        wait_idle(200, ok);
        chk("single_idle", 32'(ok), 32'd1);
        tick(20);
        chk("single_nres", 32'(res_cnt - base), 32'd4);
        chk("single_busy", 32'(core_status[0]), 32'd0);
        chk("single_req", 32'(adc_req), 32'd0);
        ctrl_start = 1'b0;
        tick(1);
`endif

        // reset in the middle of a scan
        adc_mode = 2; irq_en = 3'b111;
        ctrl_start = 1'b1;
        tick(1);
        ctrl_start = 1'b0;
        tick(12);
        chk("midrst_busy", 32'(core_status[0]), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("midrst_status", 32'(core_status), 32'h0);
        chk("midrst_req", 32'(adc_req), 32'd0);
        chk("midrst_resd", 32'(res_data), 32'h0);
        chk("midrst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
